// File: rtl/hs_channel_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs_channel_arbiter: round-robin arbiter feeding a four-phase req/ack CDC
// channel from N local requesters. Revision: 1.0
// ----------------------------------------------------------------------------
module hs_channel_arbiter #(
  parameter int N  = 4,
  parameter int DW = 4
) (
  input  logic                 clk_a,
  input  logic                 rst_n,
  input  logic [N-1:0]         src_valid,
  input  logic [N*DW-1:0]      src_data,
  output logic [N-1:0]         src_ready,
  output logic                 data_req,
  output logic [DW-1:0]        data,
  input  logic                 data_ack,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_ack_meta;
  logic          r_ack_s;
  logic [1:0]    r_warm;
  logic [IW-1:0] r_ptr;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_word;

  // First valid requester after the pointer, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % N);
      if (!w_found && src_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_word = src_data[int'(w_win)*DW +: DW];

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_warm     <= 2'b00;
      r_ptr      <= IW'(N-1);
      src_ready  <= '0;
      data_req   <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
    end else begin
      r_ack_meta <= data_ack;
      r_ack_s    <= r_ack_meta;
      // Grants wait until the synchronizer holds real samples, so an ack
      // still high across reset cannot be mistaken for a low one.
      r_warm     <= {r_warm[0], 1'b1};
      src_ready  <= '0;
      case (r_state)
        S_IDLE: begin
          if (r_warm[1] && !r_ack_s && w_found) begin
            data     <= w_word;
            grant_id <= w_win;
            r_ptr    <= w_win;
            data_req <= 1'b1;
            busy     <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (r_ack_s) begin
            data_req            <= 1'b0;
            src_ready[grant_id] <= 1'b1;
            r_state             <= S_DROP;
          end
        end
        S_DROP: begin
          if (!r_ack_s) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          data_req <= 1'b0;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_channel_arbiter.sv
`default_nettype none
`timescale 1ns/100ps
// ----------------------------------------------------------------------------
// tb_hs_channel_arbiter: random requesters and a clk_b receiver model, checked
// by a round-robin scoreboard. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_hs_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int IW = $clog2(N);

  logic             clk_a = 1'b0;
  logic             clk_b = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     src_valid = '0;
  logic [N*DW-1:0]  src_data = '0;
  logic [N-1:0]     src_ready;
  logic             data_req;
  logic [DW-1:0]    data;
  logic             data_ack = 1'b0;
  logic             busy;
  logic [IW-1:0]    grant_id;

  hs_channel_arbiter #(.N(N), .DW(DW)) dut (
    .clk_a     (clk_a),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .data_req  (data_req),
    .data      (data),
    .data_ack  (data_ack),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5    clk_a = ~clk_a;
  always #15.5 clk_b = ~clk_b;

  int errors = 0;
  int checks = 0;
  int issued = 0;
  int served = 0;

  logic [DW-1:0] drv_q [N][$];
  logic [DW-1:0] exp_q [N][$];
  logic [DW-1:0] rx_exp [$];
  logic [N-1:0]  wd = '0;
  bit            withdraw_en = 1'b0;
  bit            hold_ack = 1'b0;
  int            rx_max = 3;

  logic [N-1:0]  v_snap = '0;
  logic          ack_d1 = 1'b0, ack_d2 = 1'b0, ack_d3 = 1'b0;

  int            mptr = N-1;
  int            cur_g = 0;
  int            w;
  logic [DW-1:0] cur_w = '0;
  bit            in_flight = 1'b0;
  bit            active = 1'b0;
  bit            prev_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic add_word(input int i, input logic [DW-1:0] wv);
    drv_q[i].push_back(wv);
    exp_q[i].push_back(wv);
    issued++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (drv_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Round-robin rule: first valid index after the last winner, modulo N.
  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Requester driver: presents the head word, pops it on src_ready.
  initial forever begin
    @(posedge clk_a);
    #2;
    for (int i = 0; i < N; i++) begin
      if (src_ready[i]) begin
        if (drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        wd[i] = 1'b0;
      end
      if (!rst_n) wd[i] = 1'b0;
      else if (withdraw_en && busy && data_req && int'(grant_id) == i &&
               $urandom_range(0, 5) == 0)
        wd[i] = 1'b1;
      src_valid[i] = (drv_q[i].size() > 0) && !wd[i];
      src_data[i*DW +: DW] = (drv_q[i].size() > 0) ? drv_q[i][0] : '0;
    end
  end

  // Inputs as the DUT sees them at each clk_a edge.
  initial forever begin
    @(posedge clk_a);
    v_snap = src_valid;
    ack_d3 = ack_d2;
    ack_d2 = ack_d1;
    ack_d1 = data_ack;
  end

  // Receiver in clk_b: synchronise req, wait a random delay, capture, ack.
  initial begin
    logic r1, r2;
    int   cnt, dly;
    r1 = 1'b0; r2 = 1'b0; cnt = 0; dly = 2;
    forever begin
      @(posedge clk_b);
      r2 = r1;
      r1 = data_req;
      if (data_ack) begin
        if (!r2 && !hold_ack) data_ack = 1'b0;
      end else if (r2) begin
        if (cnt < dly) cnt++;
        else begin
          if (rx_exp.size() > 0) chk("rx_word", data, rx_exp.pop_front());
          else chk("rx_unexpected_req", 1, 0);
          data_ack = 1'b1;
          cnt = 0;
          dly = ($urandom_range(0, 3) == 0) ? rx_max : int'($urandom_range(0, rx_max));
        end
      end
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk_a);
    if (!rst_n) begin
      in_flight = 1'b0;
      active    = 1'b0;
      mptr      = N-1;
      prev_req  = 1'b0;
    end else begin
      if (data_req && !prev_req) begin
        w = rr_pick(mptr, v_snap);
        if (w < 0) begin
          chk("grant_without_valid", 32'(grant_id) + 1, 0);
        end else begin
          chk("grant_id", 32'(grant_id), w);
          chk("grant_data", 32'(data), exp_q[w].size() > 0 ? 32'(exp_q[w][0]) : 32'hDEAD);
          cur_g = w;
          cur_w = (exp_q[w].size() > 0) ? exp_q[w][0] : '0;
          mptr  = w;
          rx_exp.push_back(cur_w);
        end
        chk("ack_low_at_grant", 32'(ack_d3), 0);
        chk("grant_while_in_flight", 32'(in_flight), 0);
        chk("busy_at_grant", 32'(busy), 1);
        in_flight = 1'b1;
        active    = 1'b1;
      end
      if (active && busy) begin
        chk("data_hold", 32'(data), 32'(cur_w));
        chk("grant_id_hold", 32'(grant_id), cur_g);
      end
      if (active && !busy) begin
        chk("ready_before_idle", 32'(in_flight), 0);
        active    = 1'b0;
        in_flight = 1'b0;
      end
      if (src_ready != '0) begin
        chk("src_ready", 32'(src_ready), in_flight ? (32'(1) << cur_g) : 0);
        chk("req_low_at_ready", 32'(data_req), 0);
        if (in_flight) begin
          if (exp_q[cur_g].size() > 0) void'(exp_q[cur_g].pop_front());
          served++;
          in_flight = 1'b0;
        end
      end
      prev_req = data_req;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_req"},  32'(data_req),  0);
    chk({tag, "_data"},      32'(data),      0);
    chk({tag, "_src_ready"}, 32'(src_ready), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_grant_id"},  32'(grant_id),  0);
  endtask

  task automatic drain(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk_a);
      #1;
      n++;
      done = all_empty() && !busy && !data_req && !data_ack;
    end
    chk("drain_timeout", 32'(done), 1);
  endtask

  initial begin
    int  n;
    bit  hit;
    repeat (3) @(posedge clk_a);
    #1;
    chk_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // Single requester, word A.
    rx_max = 3;
    add_word(0, 4'hA);
    drain(2000);

    // All requesters hold one word each.
    for (int i = 0; i < N; i++) add_word(i, DW'(i + 1));
    drain(4000);

    // Random traffic, withdrawals and slow receiver.
    withdraw_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk_a);
      #1;
      rx_max = (c < 300) ? 4 : 20;
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = int'($urandom_range(0, N-1));
        if (drv_q[i].size() < 3) add_word(i, DW'($urandom));
      end
    end
    drain(30000);
    withdraw_en = 1'b0;

    // Reset in the middle of a handshake with ack held high.
    rx_max = 2;
    for (int i = 0; i < N; i++) add_word(i, DW'($urandom));
    n = 0;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      @(posedge clk_a);
      #1;
      n++;
      hit = data_req && data_ack;
    end
    chk("reset_window_found", 32'(hit), 1);
    hold_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    repeat (2) @(posedge clk_a);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_a);
      #1;
      chk("no_req_on_stale_ack", 32'(data_req), 0);
    end
    hold_ack = 1'b0;
    drain(8000);

    chk("served_count", 32'(served), 32'(issued));
    chk("rx_all_captured", 32'(rx_exp.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
